// File: rtl/axil_reg_master_pkg.sv
// Shared definitions for the AXI-Lite register master: FSM encoding,
// AXI response codes and fixed widths.
package axil_reg_master_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int RESP_W = 2;
    localparam int ERR_W  = 16;

    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/axil_reg_master.sv
// Single-outstanding AXI-Lite master turning a simple command/response
// handshake into register reads and writes.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR_REQ  | AW and W offered, each dropped once its own handshake completes
// WR_RESP | BREADY high, waiting for the write response
// RD_REQ  | AR offered until ARREADY
// RD_RESP | RREADY high, waiting for read data
// DONE    | rsp_valid held with stable fields until rsp_ready
module axil_reg_master
    import axil_reg_master_pkg::*;
#(
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          C_M_AXI_ADDR_WIDTH = 12,
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [RESP_W-1:0]               rsp_resp,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [RESP_W-1:0]               M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [RESP_W-1:0]               M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,

    output logic [ERR_W-1:0]                err_count
);

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = C_BASE_ADDRESS[C_M_AXI_ADDR_WIDTH-1:0];

    state_e                            state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                              awvalid_q, awvalid_d;
    logic                              wvalid_q, wvalid_d;
    logic                              arvalid_q, arvalid_d;
    logic                              cmd_ready_q, cmd_ready_d;
    logic                              rsp_write_q, rsp_write_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [RESP_W-1:0]                 rsp_resp_q, rsp_resp_d;
    logic [ERR_W-1:0]                  err_count_q, err_count_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr ^ BASE_ADDR;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                // A channel whose valid is already low has finished its handshake.
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY))
                    state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                    if (M_AXI_BRESP != RESP_OKAY && err_count_q != ERR_MAX)
                        err_count_d = err_count_q + 16'd1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    if (M_AXI_RRESP != RESP_OKAY && err_count_q != ERR_MAX)
                        err_count_d = err_count_q + 16'd1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered so it stays low through reset and rises one cycle after.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = (state_q == ST_DONE);
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == ST_RD_RESP);
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_axil_reg_master.sv
// Directed bench for axil_reg_master with a configurable-latency AXI-Lite
// slave model; base address 0x100 so address translation is visible.
module tb_axil_reg_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [15:0] err_count;

    axil_reg_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(12),
        .C_BASE_ADDRESS    (32'h0000_0100)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Slave model configuration
    int          aw_wait = 0, w_wait = 0, r_wait = 0;
    logic [31:0] rdata_cfg = '0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    int          aw_cnt, w_cnt, r_cnt, wr_count, rd_count;
    logic        aw_got, w_got, r_pend;
    logic [11:0] last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    assign awready = awvalid && (aw_cnt == aw_wait);
    assign wready  = wvalid  && (w_cnt  == w_wait);
    assign arready = arvalid;
    assign rdata   = rdata_cfg;
    assign rresp   = rresp_cfg;
    assign bresp   = bresp_cfg;

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            wr_count <= 0; rd_count <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0;
            last_awaddr <= '0; last_araddr <= '0; last_wdata <= '0; last_wstrb <= '0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (wvalid && !wready)   w_cnt  <= w_cnt + 1;
            if (awvalid && awready) begin
                aw_cnt <= 0; aw_got <= 1'b1; last_awaddr <= awaddr;
            end
            if (wvalid && wready) begin
                w_cnt <= 0; w_got <= 1'b1; last_wdata <= wdata; last_wstrb <= wstrb;
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1; wr_count <= wr_count + 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;

            if (arvalid && arready) begin
                last_araddr <= araddr;
                rd_count    <= rd_count + 1;
                if (r_wait == 0) rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= r_wait; end
            end
            if (r_pend) begin
                r_cnt <= r_cnt - 1;
                if (r_cnt == 1) begin rvalid <= 1'b1; r_pend <= 1'b0; end
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    int n_tests = 0, n_fail = 0;
    int lat, aw_cyc, w_cyc, ar_cyc, aw_hs_at, w_hs_at, n;
    logic [31:0] hold_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        lat = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_hs_at = -1; w_hs_at = -1;
        do begin
            @(negedge clk);
            lat++;
            if (awvalid) aw_cyc++;
            if (wvalid)  w_cyc++;
            if (arvalid) ar_cyc++;
            if (awvalid && awready) aw_hs_at = lat;
            if (wvalid && wready)   w_hs_at  = lat;
        end while (!rsp_valid && lat < 100);
        check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {25'd0, cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        check("rst_rsp", {rsp_rdata[15:0], 12'd0, rsp_write, rsp_resp, 1'b0}, 32'd0);
        check("rst_err", {16'd0, err_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Zero-wait write
        send_cmd(1'b1, 12'h010, 32'hA5A5_A5A5, 4'hF);
        wait_rsp();
        check("wr0_latency", lat, 32'd3);
        check("wr0_aw_hs", aw_hs_at, 32'd1);
        check("wr0_w_hs", w_hs_at, 32'd1);
        check("wr0_resp", {29'd0, rsp_write, rsp_resp}, 32'h4);
        check("wr0_rdata", rsp_rdata, 32'd0);
        check("wr0_awaddr", {20'd0, last_awaddr}, 32'h110);
        check("wr0_wdata", last_wdata, 32'hA5A5_A5A5);
        check("wr0_wstrb", {28'd0, last_wstrb}, 32'hF);
        check("wr0_err", {16'd0, err_count}, 32'd0);
        consume();

        // AWREADY delayed by 4 cycles, WREADY immediate
        aw_wait = 4;
        send_cmd(1'b1, 12'h024, 32'h1234_5678, 4'h3);
        wait_rsp();
        check("wr1_w_cycles", w_cyc, 32'd1);
        check("wr1_aw_cycles", aw_cyc, 32'd5);
        check("wr1_latency", lat, 32'd7);
        check("wr1_count", wr_count, 32'd2);
        check("wr1_awaddr", {20'd0, last_awaddr}, 32'h124);
        check("wr1_wdata", last_wdata, 32'h1234_5678);
        check("wr1_wstrb", {28'd0, last_wstrb}, 32'h3);
        consume();
        aw_wait = 0;

        // Read with two RVALID wait cycles
        r_wait = 2; rdata_cfg = 32'hDEAD_BEEF;
        send_cmd(1'b0, 12'h000, 32'd0, 4'h0);
        wait_rsp();
        check("rd0_latency", lat, 32'd5);
        check("rd0_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd0_resp", {29'd0, rsp_write, rsp_resp}, 32'd0);
        check("rd0_araddr", {20'd0, last_araddr}, 32'h100);
        check("rd0_no_aw", aw_cyc, 32'd0);
        consume();
        r_wait = 0;

        // Three SLVERR reads
        rresp_cfg = 2'b10;
        for (int i = 0; i < 3; i++) begin
            rdata_cfg = 32'h100 + i;
            send_cmd(1'b0, 12'h040, 32'd0, 4'h0);
            wait_rsp();
            check("rderr_latency", lat, 32'd3);
            check("rderr_resp", {30'd0, rsp_resp}, 32'h2);
            check("rderr_rdata", rsp_rdata, 32'h100 + i);
            consume();
            check("rderr_count", {16'd0, err_count}, i + 1);
        end
        rresp_cfg = 2'b00;

        // Response back-pressure with a competing command offered
        rdata_cfg = 32'h0BAD_F00D;
        send_cmd(1'b0, 12'h008, 32'd0, 4'h0);
        wait_rsp();
        hold_rdata = rsp_rdata;
        check("hold_rdata0", hold_rdata, 32'h0BAD_F00D);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h0FF; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_ctrl", {27'd0, rsp_valid, cmd_ready, awvalid, wvalid, arvalid}, 32'h10);
            check("hold_fields", {rsp_rdata[27:0], 1'b0, rsp_write, rsp_resp}, {hold_rdata[27:0], 4'h0});
        end
        cmd_valid = 1'b0;
        consume();
        check("hold_no_write", wr_count, 32'd2);
        check("hold_err", {16'd0, err_count}, 32'd3);

        // Saturation near the top of the error counter
        @(negedge clk);
        force dut.err_count_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.err_count_q;
        @(negedge clk);
        check("sat_preload", {16'd0, err_count}, 32'hFFFE);
        rresp_cfg = 2'b10;
        send_cmd(1'b0, 12'h010, 32'd0, 4'h0);
        wait_rsp();
        consume();
        check("sat_first", {16'd0, err_count}, 32'hFFFF);
        send_cmd(1'b0, 12'h014, 32'd0, 4'h0);
        wait_rsp();
        consume();
        check("sat_hold", {16'd0, err_count}, 32'hFFFF);
        rresp_cfg = 2'b00;

        // Reset while waiting in RD_RESP
        r_wait = 5;
        send_cmd(1'b0, 12'h020, 32'd0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("mid_in_rd_resp", {31'd0, rready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", {25'd0, cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        check("mid_rst_err", {16'd0, err_count}, 32'd0);
        reset = 1'b0; r_wait = 0; rdata_cfg = 32'h600D_CAFE;
        send_cmd(1'b0, 12'h008, 32'd0, 4'h0);
        wait_rsp();
        check("post_rst_latency", lat, 32'd3);
        check("post_rst_rdata", rsp_rdata, 32'h600D_CAFE);
        check("post_rst_araddr", {20'd0, last_araddr}, 32'h108);
        check("post_rst_resp", {29'd0, rsp_write, rsp_resp}, 32'd0);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_reg_master.md
AXIL_REG_MASTER -- requirements
Module: axil_reg_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 12, AXI-Lite address width.
REQ-003 SHALL have parameter C_BASE_ADDRESS, default 32'h00000000, XORed onto every issued address (low C_M_AXI_ADDR_WIDTH bits).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk in 1, rising-edge clock for all logic; reset in 1, synchronous active-high reset.
REQ-005 SHALL have these command ports: cmd_valid in 1, command offered; cmd_ready out 1, command accepted; cmd_write in 1, 1 = write and 0 = read; cmd_addr in ADDR, register offset; cmd_wdata in 32, write data; cmd_wstrb in 4, byte strobes.
REQ-006 SHALL have these response ports: rsp_valid out 1, result available; rsp_ready in 1, result consumed; rsp_write out 1, echoes cmd_write; rsp_rdata out 32, read data (0 for writes); rsp_resp out 2, BRESP/RRESP.
REQ-007 SHALL have these AXI master ports: M_AXI_AWADDR out ADDR, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1, M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1, M_AXI_ARADDR out ADDR, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.
REQ-008 SHALL have port err_count out 16, saturating count of non-OKAY responses.

Function
REQ-009 SHALL have FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, and SHALL keep at most one transaction outstanding.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; a command is accepted when cmd_valid & cmd_ready; accepted fields are registered; next state is WR_REQ if cmd_write=1, else RD_REQ.
REQ-011 In WR_REQ, SHALL assert AWVALID and WVALID together on the first cycle; each valid SHALL drop the cycle after its own ready is sampled high; the AW and W handshakes are independent (either order, or the same cycle); state SHALL go to WR_RESP once both have completed.
REQ-012 SHALL hold AWADDR, WDATA and WSTRB stable while the corresponding valid is high; a valid SHALL never be withdrawn before its handshake completes.
REQ-013 In WR_RESP, SHALL assert BREADY=1; on BVALID, SHALL latch BRESP, set rdata=0 and go to DONE.
REQ-014 In RD_REQ, SHALL assert ARVALID with a stable ARADDR until ARREADY, then go to RD_RESP.
REQ-015 In RD_RESP, SHALL assert RREADY=1; on RVALID, SHALL latch RDATA and RRESP and go to DONE.
REQ-016 In DONE, SHALL hold rsp_valid=1 with stable fields until rsp_ready, then return to IDLE; a new command SHALL be accepted no earlier than the cycle after that.
REQ-017 SHALL set issued address = cmd_addr XOR C_BASE_ADDRESS[ADDR-1:0].
REQ-018 SHALL increment err_count when a latched resp != 2'b00, saturating at 16'hFFFF; it SHALL never wrap.
REQ-019 Minimum latency: command accept to rsp_valid = 3 cycles when the slave responds with zero wait states.
REQ-020 BREADY and RREADY SHALL be low outside their response states; any B/R beat arriving then is a slave protocol violation and SHALL be ignored.

Reset
REQ-021 While reset=1 at a clk edge, SHALL set: state=IDLE; all M_AXI valids/readys=0; cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_resp=0; rsp_write=0; err_count=0. cmd_ready SHALL go to 1 the first cycle after reset deasserts.
REQ-022 Reset mid-transaction SHALL abandon it with no response; the bench SHALL reset the slave together with this block.

Structure
REQ-023 A shared package SHALL hold: the FSM state encoding; the AXI response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3); and the width constants.
REQ-024 SHALL be a single module; no sub-module is required.

Verification
REQ-025 Write 0x10=0xA5A5A5A5, strb 0xF, zero-wait slave -> AW and W in the same cycle, rsp_valid 3 cycles after accept, resp=0, err_count=0.
REQ-026 Write with AWREADY delayed 4 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 5 cycles, exactly one write observed at the slave.
REQ-027 Read 0x0 from a slave returning 0xDEADBEEF after 2 RVALID wait cycles -> rsp_rdata=0xDEADBEEF, resp=0, rsp_write=0.
REQ-028 Three reads each returning RRESP=2'b10 -> err_count=3; force err_count=0xFFFE, issue two error reads -> err_count=0xFFFF.
REQ-029 Hold rsp_ready=0 for 10 cycles -> rsp fields stable and cmd_ready=0 throughout; no new AW/AR issued.
REQ-030 Assert reset during RD_RESP -> next cycle all valids=0, cmd_ready=0, rsp_valid=0; a following read completes normally.
